aer_lrf_stride_mapper: RTL



---
 rtl/aer_lrf_stride_mapper_pkg.sv | 39 +++
 rtl/aer_lrf_stride_mapper_axis_window.sv | 31 +++
 rtl/aer_lrf_stride_mapper.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aer_lrf_stride_mapper_pkg.sv
// Shared types and width helpers for the strided LRF event mapper.
package lrf_mapper_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    ACK_UP = 3'd4
  } state_e;

  // Field width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Upstream address: {type[1:0], c, y, x}.
  function automatic int in_addr_w(input int fm_c, input int fm_h, input int fm_w);
    return 2 + clog2_min1(fm_c) + clog2_min1(fm_h) + clog2_min1(fm_w);
  endfunction

  // Core-local address: {type[1:0], c, ky, kx}.
  function automatic int loc_addr_w(input int fm_c, input int lrf_h, input int lrf_w);
    return 2 + clog2_min1(fm_c) + clog2_min1(lrf_h) + clog2_min1(lrf_w);
  endfunction

  // Signed window-offset width, wide enough that coord+PAD-idx*STRIDE never wraps.
  function automatic int off_w(input int fm_w, input int fm_h, input int pad,
                               input int stride, input int core_w, input int core_h);
    int fm_max;
    int core_max;
    fm_max   = (fm_w > fm_h) ? fm_w : fm_h;
    core_max = (core_w > core_h) ? core_w : core_h;
    return $clog2(fm_max + pad) + $clog2(stride * core_max) + 2;
  endfunction

endpackage

// File: rtl/aer_lrf_stride_mapper_axis_window.sv
// One axis of the receptive-field test: offset k = coord + PAD - out_idx*STRIDE,
// hit when 0 <= k < LRF. Purely combinational.
module lrf_axis_window #(
  parameter int COORD_W = 4,
  parameter int IDX_W   = 3,
  parameter int OFF_W   = 11,
  parameter int K_W     = 2,
  parameter int LRF     = 3,
  parameter int STRIDE  = 2,
  parameter int PAD     = 1
) (
  input  logic [COORD_W-1:0] coord,
  input  logic [IDX_W-1:0]   out_idx,
  output logic               hit,
  output logic [K_W-1:0]     k
);

  localparam logic signed [OFF_W-1:0] LRF_S    = OFF_W'(LRF);
  localparam logic signed [OFF_W-1:0] STRIDE_S = OFF_W'(STRIDE);
  localparam logic signed [OFF_W-1:0] PAD_S    = OFF_W'(PAD);

  logic signed [OFF_W-1:0] k_s;

  // Signed offset into the window and the in-range test.
  always_comb begin
    k_s = $signed(OFF_W'(coord)) + PAD_S - ($signed(OFF_W'(out_idx)) * STRIDE_S);
    hit = (k_s[OFF_W-1] == 1'b0) && (k_s < LRF_S);
    k   = k_s[K_W-1:0];
  end

endmodule

// File: rtl/aer_lrf_stride_mapper.sv
// Strided/padded LRF mapper: fans one AER event out to every output core whose
// window covers it, gathers the per-core four-phase handshakes, then acks upstream.
// Optional statistics counters are built when LRF_MAPPER_STATS_EN is defined.
module aer_lrf_stride_mapper
  import lrf_mapper_pkg::*;
#(
  parameter int FM_W   = 16,
  parameter int FM_H   = 16,
  parameter int FM_C   = 3,
  parameter int CORE_W = 8,
  parameter int CORE_H = 8,
  parameter int LRF_W  = 3,
  parameter int LRF_H  = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  localparam int CORE_NUM = CORE_W * CORE_H,
  localparam int AW       = in_addr_w(FM_C, FM_H, FM_W),
  localparam int LW       = loc_addr_w(FM_C, LRF_H, LRF_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   AERIN_REQ,
  input  logic [AW-1:0]          AERIN_ADDR,
  output logic                   AERIN_ACK,
  output logic [CORE_NUM-1:0]    CORE_REQ,
  output logic [CORE_NUM*LW-1:0] CORE_ADDR,
  input  logic [CORE_NUM-1:0]    CORE_ACK
`ifdef LRF_MAPPER_STATS_EN
  ,
  input  logic                   STAT_CLR,
  output logic [31:0]            STAT_EVT,
  output logic [15:0]            STAT_DROP,
  output logic [31:0]            STAT_FANOUT
`endif
);

  localparam int XW    = clog2_min1(FM_W);
  localparam int YW    = clog2_min1(FM_H);
  localparam int CW    = clog2_min1(FM_C);
  localparam int KXW   = clog2_min1(LRF_W);
  localparam int KYW   = clog2_min1(LRF_H);
  localparam int OFFW  = off_w(FM_W, FM_H, PAD, STRIDE, CORE_W, CORE_H);
  localparam int IDX_W = clog2_min1((CORE_W > CORE_H) ? CORE_W : CORE_H);

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [CORE_NUM-1:0]   hit_mask_q, hit_mask_d;
  logic [CORE_NUM-1:0]   acked_q, acked_d;
  logic [CORE_NUM-1:0]   core_req_q, core_req_d;
  logic [CORE_NUM*LW-1:0] core_addr_q, core_addr_d;
  logic                  aerin_ack_q, aerin_ack_d;

  logic [XW-1:0]  x_s;
  logic [YW-1:0]  y_s;
  logic [CW-1:0]  c_s;
  logic [1:0]     type_s;
  logic           valid_s;
  logic [CORE_W-1:0] hx_s;
  logic [CORE_H-1:0] hy_s;
  logic [KXW-1:0] kx_s [CORE_W];
  logic [KYW-1:0] ky_s [CORE_H];
  logic [CORE_NUM-1:0]    hit_s;
  logic [CORE_NUM*LW-1:0] laddr_s;

  // Split the latched event and reject out-of-range coordinates/channels.
  always_comb begin
    x_s     = addr_q[XW-1:0];
    y_s     = addr_q[XW +: YW];
    c_s     = addr_q[XW+YW +: CW];
    type_s  = addr_q[AW-1 -: 2];
    valid_s = (int'(c_s) < FM_C) && (int'(x_s) < FM_W) && (int'(y_s) < FM_H);
  end

  for (genvar gx = 0; gx < CORE_W; gx++) begin : g_col
    lrf_axis_window #(
      .COORD_W(XW), .IDX_W(IDX_W), .OFF_W(OFFW), .K_W(KXW),
      .LRF(LRF_W), .STRIDE(STRIDE), .PAD(PAD)
    ) u_win_x (
      .coord(x_s), .out_idx(IDX_W'(gx)), .hit(hx_s[gx]), .k(kx_s[gx])
    );
  end

  for (genvar gy = 0; gy < CORE_H; gy++) begin : g_row
    lrf_axis_window #(
      .COORD_W(YW), .IDX_W(IDX_W), .OFF_W(OFFW), .K_W(KYW),
      .LRF(LRF_H), .STRIDE(STRIDE), .PAD(PAD)
    ) u_win_y (
      .coord(y_s), .out_idx(IDX_W'(gy)), .hit(hy_s[gy]), .k(ky_s[gy])
    );
  end

  // A core is hit when both its row and its column window contain the event.
  always_comb begin
    hit_s   = '0;
    laddr_s = '0;
    for (int oy = 0; oy < CORE_H; oy++) begin
      for (int ox = 0; ox < CORE_W; ox++) begin
        hit_s[oy*CORE_W+ox]        = valid_s & hx_s[ox] & hy_s[oy];
        laddr_s[(oy*CORE_W+ox)*LW +: LW] = {type_s, c_s, ky_s[oy], kx_s[ox]};
      end
    end
  end

  // Handshake sequencing: latch, compute fan-out, issue, drain, ack upstream.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hit_mask_d  = hit_mask_q;
    acked_d     = acked_q;
    core_req_d  = core_req_q;
    core_addr_d = core_addr_q;
    aerin_ack_d = aerin_ack_q;
    case (state_q)
      IDLE: begin
        if (AERIN_REQ) begin
          addr_d  = AERIN_ADDR;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        hit_mask_d  = hit_s;
        core_addr_d = laddr_s;
        acked_d     = '0;
        if (hit_s == '0) begin
          aerin_ack_d = 1'b1;
          state_d     = ACK_UP;
        end else begin
          core_req_d = hit_s;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        acked_d    = acked_q | (CORE_ACK & hit_mask_q);
        core_req_d = hit_mask_q & ~acked_d;
        if (acked_d == hit_mask_q) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        core_req_d = '0;
        if ((CORE_ACK & hit_mask_q) == '0) begin
          aerin_ack_d = 1'b1;
          state_d     = ACK_UP;
        end else begin
          state_d = DRAIN;
        end
      end
      ACK_UP: begin
        if (!AERIN_REQ) begin
          aerin_ack_d = 1'b0;
          state_d     = IDLE;
        end else begin
          aerin_ack_d = 1'b1;
        end
      end
      default: begin
        core_req_d  = '0;
        aerin_ack_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      hit_mask_q  <= '0;
      acked_q     <= '0;
      core_req_q  <= '0;
      core_addr_q <= '0;
      aerin_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hit_mask_q  <= hit_mask_d;
      acked_q     <= acked_d;
      core_req_q  <= core_req_d;
      core_addr_q <= core_addr_d;
      aerin_ack_q <= aerin_ack_d;
    end
  end

  assign AERIN_ACK = aerin_ack_q;
  assign CORE_REQ  = core_req_q;
  assign CORE_ADDR = core_addr_q;

`ifdef LRF_MAPPER_STATS_EN
  logic [31:0] stat_evt_q, stat_evt_d;
  logic [15:0] stat_drop_q, stat_drop_d;
  logic [31:0] stat_fanout_q, stat_fanout_d;
  logic [31:0] pop_s;
  logic [32:0] fsum_s;

  // Saturating event/drop/fan-out counters, updated as each event is evaluated.
  always_comb begin
    pop_s = 32'd0;
    for (int i = 0; i < CORE_NUM; i++) begin
      pop_s = pop_s + {31'd0, hit_s[i]};
    end
    fsum_s        = {1'b0, stat_fanout_q} + {1'b0, pop_s};
    stat_evt_d    = stat_evt_q;
    stat_drop_d   = stat_drop_q;
    stat_fanout_d = stat_fanout_q;
    if (STAT_CLR) begin
      stat_evt_d    = 32'd0;
      stat_drop_d   = 16'd0;
      stat_fanout_d = 32'd0;
    end else if (state_q == CALC) begin
      stat_evt_d    = (stat_evt_q == 32'hFFFF_FFFF) ? stat_evt_q : stat_evt_q + 32'd1;
      if (hit_s == '0) begin
        stat_drop_d = (stat_drop_q == 16'hFFFF) ? stat_drop_q : stat_drop_q + 16'd1;
      end else begin
        stat_drop_d = stat_drop_q;
      end
      stat_fanout_d = fsum_s[32] ? 32'hFFFF_FFFF : fsum_s[31:0];
    end else begin
      stat_evt_d    = stat_evt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_evt_q    <= 32'd0;
      stat_drop_q   <= 16'd0;
      stat_fanout_q <= 32'd0;
    end else begin
      stat_evt_q    <= stat_evt_d;
      stat_drop_q   <= stat_drop_d;
      stat_fanout_q <= stat_fanout_d;
    end
  end

  assign STAT_EVT    = stat_evt_q;
  assign STAT_DROP   = stat_drop_q;
  assign STAT_FANOUT = stat_fanout_q;
`endif

endmodule
